// File: rtl/serial_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | serial_ctrl_if : group handshake and output-memory write port            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface serial_ctrl_if #(
  parameter int MWIDTH = 12
) ();
  logic              vec_valid;
  logic              vec_ready;
  logic              serial_we;
  logic              mem_we;
  logic [MWIDTH-1:0] mem_addr;

  // master: core side presenting result groups; slave: the sequencer
  modport master (
    output vec_valid,
    input  vec_ready,
    input  serial_we,
    input  mem_we,
    input  mem_addr
  );

  modport slave (
    input  vec_valid,
    output vec_ready,
    output serial_we,
    output mem_we,
    output mem_addr
  );
endinterface
`default_nettype wire

// File: rtl/serial_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | serial_ctrl : vector-to-serial output sequencer (accept group, shift     |
// | CORE lanes, gate memory writes, pulse done).                             |
// | Optional macro SERIAL_CTRL_OVERLAP_EN: accept next group in last shift.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module serial_ctrl #(
  parameter int CORE   = 8,
  parameter int LWIDTH = 10,
  parameter int MWIDTH = 12
) (
  input  wire logic              clk,
  input  wire logic              xrst,
  input  wire logic              start,
  input  wire logic [LWIDTH-1:0] out_size,
  input  wire logic [MWIDTH-1:0] base_addr,
  serial_ctrl_if.slave           bus,
  output logic                   busy,
  output logic                   done
);

  localparam int            CW     = $clog2(CORE + 1);
  localparam logic [CW-1:0] C_CORE = CW'(CORE);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
`ifdef SERIAL_CTRL_OVERLAP_EN
  localparam logic          C_OVERLAP = 1'b1;
`else
  localparam logic          C_OVERLAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            r_state;
  logic [LWIDTH-1:0] r_size;
  logic [MWIDTH-1:0] r_addr;
  logic [LWIDTH:0]   r_written;
  logic [CW-1:0]     r_cnt;
  logic              r_vec_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_we;
  logic              w_last;
  logic              w_more;
  logic              w_more_ahead;
  logic [LWIDTH:0]   w_size_ext;
  logic [LWIDTH:0]   w_written_nxt;
  logic [LWIDTH:0]   w_written_nxt_p1;

  assign w_size_ext       = {1'b0, r_size};
  assign w_accept         = bus.vec_valid & r_vec_ready;
  assign w_we             = (r_state == SHIFT) && (r_written < w_size_ext);
  assign w_written_nxt    = r_written + {{LWIDTH{1'b0}}, w_we};
  assign w_written_nxt_p1 = w_written_nxt + {{LWIDTH{1'b0}}, 1'b1};
  assign w_last           = (r_cnt == C_CORE);
  assign w_more           = (w_written_nxt < w_size_ext);
  // Lookahead one cycle: does the final shift cycle still leave outputs pending?
  assign w_more_ahead     = (w_written_nxt_p1 < w_size_ext);

  assign bus.vec_ready = r_vec_ready;
  assign bus.serial_we = w_accept;
  assign bus.mem_we    = w_we;
  assign bus.mem_addr  = r_addr + MWIDTH'(r_written);
  assign busy          = r_busy;
  assign done          = r_done;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state     <= IDLE;
      r_size      <= '0;
      r_addr      <= '0;
      r_written   <= '0;
      r_cnt       <= '0;
      r_vec_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_size    <= out_size;
            r_addr    <= base_addr;
            r_written <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            if (out_size == '0) begin
              r_state     <= FIN;
              r_done      <= 1'b1;
              r_vec_ready <= 1'b0;
            end else begin
              r_state     <= WAIT;
              r_vec_ready <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (w_accept) begin
            r_state     <= SHIFT;
            r_cnt       <= C_ONE;
            r_vec_ready <= 1'b0;
          end
        end
        SHIFT: begin
          r_written <= w_written_nxt;
          if (!w_last) begin
            r_cnt       <= r_cnt + C_ONE;
            r_vec_ready <= C_OVERLAP && (r_cnt == (C_CORE - C_ONE)) && w_more_ahead;
          end else if (C_OVERLAP && w_accept) begin
            r_cnt       <= C_ONE;
            r_vec_ready <= 1'b0;
          end else if (w_more) begin
            r_state     <= WAIT;
            r_vec_ready <= 1'b1;
          end else begin
            r_state     <= FIN;
            r_vec_ready <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for serial_ctrl: lane-count reference model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_serial_ctrl;
  localparam int CORE = 8;
  localparam int LW   = 10;
  localparam int MW   = 12;
`ifdef SERIAL_CTRL_OVERLAP_EN
  localparam int OVL = 1;
`else
  localparam int OVL = 0;
`endif

  logic          clk = 1'b0;
  logic          xrst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] out_size = '0;
  logic [MW-1:0] base_addr = '0;
  logic          busy;
  logic          done;

  serial_ctrl_if #(.MWIDTH(MW)) bus ();

  serial_ctrl #(.CORE(CORE), .LWIDTH(LW), .MWIDTH(MW)) dut (
    .clk       (clk),
    .xrst      (xrst),
    .start     (start),
    .out_size  (out_size),
    .base_addr (base_addr),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_n = 0;
  int done_cyc = -1;
  int start_cyc = -1;
  int wq[$];
  int aq[$];

  function automatic void check(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h) cycle=%0d", name, got, got, exp, exp, cyc);
    end
  endfunction

  // Model: a layer is a list of groups; each group shifts CORE cycles and
  // writes min(CORE, remaining) lanes at its start.
  int m_active = 0, m_fin = 0, m_size = 0, m_base = 0, m_written = 0, m_pos = 0, m_lanes = 0;

  always @(negedge clk) begin : cmp
    int e_we, e_ready, e_sw, e_addr, wa;
    cyc++;
    if (!xrst) begin
      check("rst_vec_ready", int'(bus.vec_ready), 0);
      check("rst_serial_we", int'(bus.serial_we), 0);
      check("rst_mem_we", int'(bus.mem_we), 0);
      check("rst_mem_addr", int'(bus.mem_addr), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      m_active = 0; m_fin = 0; m_size = 0; m_base = 0;
      m_written = 0; m_pos = 0; m_lanes = 0;
    end else begin
      e_we    = (m_active != 0 && m_pos > 0 && m_pos <= m_lanes) ? 1 : 0;
      wa      = m_written + e_we;
      e_ready = (m_active != 0 && m_fin == 0 &&
                 (m_pos == 0 || (OVL != 0 && m_pos == CORE && wa < m_size))) ? 1 : 0;
      e_sw    = (e_ready != 0 && bus.vec_valid) ? 1 : 0;
      e_addr  = (m_base + m_written) % (1 << MW);
      check("vec_ready", int'(bus.vec_ready), e_ready);
      check("serial_we", int'(bus.serial_we), e_sw);
      check("mem_we", int'(bus.mem_we), e_we);
      check("mem_addr", int'(bus.mem_addr), e_addr);
      check("busy", int'(busy), m_active);
      check("done", int'(done), m_fin);
      if (bus.serial_we) aq.push_back(cyc);
      if (bus.mem_we) wq.push_back(int'(bus.mem_addr));
      if (done) begin done_n++; done_cyc = cyc; end
      if (start) start_cyc = cyc;
      if (m_fin != 0) begin
        m_fin = 0; m_active = 0;
      end else if (m_active == 0) begin
        if (start) begin
          m_size = int'(out_size); m_base = int'(base_addr);
          m_written = 0; m_pos = 0; m_active = 1;
          m_fin = (out_size == '0) ? 1 : 0;
        end
      end else begin
        if ((m_pos == 0 || m_pos == CORE) && e_sw != 0) begin
          m_pos = 1;
          m_lanes = (m_size - wa < CORE) ? (m_size - wa) : CORE;
        end else if (m_pos == CORE) begin
          m_pos = 0;
          m_fin = (wa == m_size) ? 1 : 0;
        end else if (m_pos > 0) begin
          m_pos++;
        end
        m_written = wa;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one layer; returns early (xrst low) once rst_w writes were seen.
  task automatic layer(input int size, input int base, input int prob, input int stall,
                       input int ign_at, input int rst_w, input int budget);
    int n;
    int d0;
    wq.delete(); aq.delete();
    d0 = done_n;
    start = 1'b1; out_size = size[LW-1:0]; base_addr = base[MW-1:0];
    bus.vec_valid = 1'b0;
    tick();
    start = 1'b0;
    n = 0;
    while (done_n == d0) begin
      n++;
      if (rst_w > 0 && wq.size() >= rst_w) begin
        xrst = 1'b0;
        return;
      end
      if (n > budget) begin
        check("layer_timeout", n, budget);
        return;
      end
      bus.vec_valid = (n <= stall) ? 1'b0 : ($urandom_range(0, 99) < prob);
      if (n == ign_at) begin
        start = 1'b1; out_size = 10'd3; base_addr = 12'hABC;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    bus.vec_valid = 1'b0;
  endtask

  initial begin : drv
    int d0;
    bus.vec_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_ready_lit", int'(bus.vec_ready), 0);
    check("reset_busy_lit", int'(busy), 0);
    check("reset_addr_lit", int'(bus.mem_addr), 0);
    tick();
    xrst = 1'b1;
    tick();

    // single partial group
    layer(5, 'h100, 100, 0, 0, 0, 100);
    check("p5_groups", aq.size(), 1);
    check("p5_writes", wq.size(), 5);
    check("p5_first_addr", (wq.size() > 0) ? wq[0] : -1, 'h100);
    check("p5_last_addr", (wq.size() > 4) ? wq[4] : -1, 'h104);
    check("p5_done_lat", (aq.size() > 0) ? done_cyc - aq[0] : -1, 9);

    // multi-group
    layer(20, 0, 100, 0, 0, 0, 200);
    check("m20_groups", aq.size(), 3);
    check("m20_writes", wq.size(), 20);
    check("m20_last_addr", (wq.size() > 19) ? wq[19] : -1, 19);
    check("m20_period", (aq.size() > 1) ? aq[1] - aq[0] : -1, (OVL != 0) ? 8 : 9);
    check("m20_done_lat", (aq.size() > 0) ? done_cyc - aq[0] : -1, (OVL != 0) ? 25 : 27);

    // two full groups, streamed when overlap is built in
    layer(16, 'h200, 100, 0, 0, 0, 200);
    check("o16_writes", wq.size(), 16);
    check("o16_done_lat", (aq.size() > 0) ? done_cyc - aq[0] : -1, (OVL != 0) ? 17 : 18);
    for (int i = 0; i < wq.size(); i++) check("o16_addr", wq[i], 'h200 + i);

    // zero size
    layer(0, 'h55, 100, 0, 0, 0, 20);
    check("z_groups", aq.size(), 0);
    check("z_writes", wq.size(), 0);
    check("z_done_lat", done_cyc - start_cyc, 1);

    // start ignored during SHIFT
    layer(8, 'h20, 100, 0, 4, 0, 100);
    check("ign_writes", wq.size(), 8);
    check("ign_last_addr", (wq.size() > 7) ? wq[7] : -1, 'h27);

    // stall in WAIT
    layer(8, 'h300, 100, 10, 0, 0, 100);
    check("stall_groups", aq.size(), 1);
    check("stall_accept_cyc", (aq.size() > 0) ? aq[0] - start_cyc : -1, 11);
    check("stall_writes", wq.size(), 8);

    // async reset mid-SHIFT
    layer(8, 'h40, 100, 0, 0, 3, 100);
    d0 = done_n;
    tick(); tick();
    xrst = 1'b1;
    repeat (4) tick();
    check("rst_no_done", done_n, d0);
    layer(8, 'h80, 100, 0, 0, 0, 100);
    check("post_rst_writes", wq.size(), 8);
    check("post_rst_first", (wq.size() > 0) ? wq[0] : -1, 'h80);

    // largest layer with address wrap
    layer(1023, 'hF00, 100, 0, 0, 0, 2000);
    check("big_writes", wq.size(), 1023);
    check("big_groups", aq.size(), 128);
    check("big_last_addr", (wq.size() > 1022) ? wq[1022] : -1, ('hF00 + 1022) % 4096);

    // randomized layers
    for (int t = 0; t < 40; t++) begin
      int sz, bs, pr;
      sz = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, CORE + 1)) : int'($urandom_range(0, 60));
      bs = int'($urandom_range(0, 4095));
      pr = int'($urandom_range(30, 100));
      layer(sz, bs, pr, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 0, (sz / CORE + 2) * 80 + 50);
      check("rnd_writes", wq.size(), sz);
      check("rnd_groups", aq.size(), (sz + CORE - 1) / CORE);
      if (sz > 0) check("rnd_last_addr", wq[wq.size() - 1], (bs + sz - 1) % 4096);
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
